// File: rtl/div64_seq.sv
// div64_seq -- multi-cycle RV64 DIV/DIVU/REM/REMU sequencer (restoring division).
//
// Also contains CLA_64bit, the 64-bit carry-lookahead adder used as the
// trial subtractor (one instance, time-shared across all iterations).
//
// Ports (div64_seq):
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   in_valid   in   operands/op valid
//   in_ready   out  high only in IDLE
//   op         in   00=DIV 01=DIVU 10=REM 11=REMU
//   dividend   in   rs1
//   divisor    in   rs2
//   out_valid  out  result valid (DONE)
//   out_ready  in   consumer accepts result
//   result     out  quotient or remainder
//   busy       out  state != IDLE
//   kill       in   abort in-flight op (only when DIV_KILL_EN is defined)
//
// Optional feature macro: DIV_KILL_EN (adds the kill port).

module CLA_64bit (
    input  logic [63:0] A,
    input  logic [63:0] B,
    input  logic        Cin,
    output logic [63:0] Result,
    output logic        Cout,
    output logic        Overflow
);
    logic [63:0] g;
    logic [63:0] p;
    logic [64:0] c;

    assign g    = A & B;
    assign p    = A ^ B;
    assign c[0] = Cin;

    // 4-bit lookahead groups; group carries chain between groups.
    for (genvar gi = 0; gi < 16; gi++) begin : g_grp
        localparam int B0 = 4 * gi;
        assign c[B0+1] = g[B0] | (p[B0] & c[B0]);
        assign c[B0+2] = g[B0+1] | (p[B0+1] & g[B0]) | (p[B0+1] & p[B0] & c[B0]);
        assign c[B0+3] = g[B0+2] | (p[B0+2] & g[B0+1]) | (p[B0+2] & p[B0+1] & g[B0])
                       | (p[B0+2] & p[B0+1] & p[B0] & c[B0]);
        assign c[B0+4] = g[B0+3] | (p[B0+3] & g[B0+2]) | (p[B0+3] & p[B0+2] & g[B0+1])
                       | (p[B0+3] & p[B0+2] & p[B0+1] & g[B0])
                       | (p[B0+3] & p[B0+2] & p[B0+1] & p[B0] & c[B0]);
    end

    assign Result   = p ^ c[63:0];
    assign Cout     = c[64];
    assign Overflow = c[64] ^ c[63];
endmodule

module div64_seq #(
    parameter int XLEN  = 64,
    parameter int CNT_W = 7
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            busy
`ifdef DIV_KILL_EN
    ,
    input  logic            kill
`endif
);
    typedef enum logic [2:0] {IDLE, PREP, ITER, FIX, DONE} state_t;

    state_t            state_q, state_d;
    logic [1:0]        op_q, op_d;
    logic [XLEN-1:0]   a_q, a_d;
    logic [XLEN-1:0]   b_q, b_d;
    logic [XLEN-1:0]   bmag_q, bmag_d;
    logic [XLEN-1:0]   rem_q, rem_d;
    logic [XLEN-1:0]   quo_q, quo_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              neg_quo_q, neg_quo_d;
    logic              neg_rem_q, neg_rem_d;
    logic [XLEN-1:0]   result_q, result_d;

    logic              kill_req;
    logic              is_signed;
    logic [XLEN-1:0]   a_mag, b_mag;
    logic              sgn_ovf;
    logic [XLEN-1:0]   shifted;
    logic [XLEN-1:0]   sum;
    logic              cout;
    logic              adder_ovf_unused;
    logic              take;
    logic [XLEN-1:0]   quo_fix, rem_fix;

`ifdef DIV_KILL_EN
    assign kill_req = kill;
`else
    assign kill_req = 1'b0;
`endif

    // Operand conditioning (PREP), using local negation rather than the adder.
    assign is_signed = ~op_q[0];
    assign a_mag     = (is_signed && a_q[XLEN-1]) ? (~a_q + 1'b1) : a_q;
    assign b_mag     = (is_signed && b_q[XLEN-1]) ? (~b_q + 1'b1) : b_q;
    assign sgn_ovf   = is_signed && (a_q == {1'b1, {(XLEN-1){1'b0}}}) && (b_q == '1);

    // Trial subtraction: shifted - |b| as shifted + ~|b| + 1.
    assign shifted = {rem_q[XLEN-2:0], quo_q[XLEN-1]};

    CLA_64bit u_cla (
        .A        (shifted),
        .B        (~bmag_q),
        .Cin      (1'b1),
        .Result   (sum),
        .Cout     (cout),
        .Overflow (adder_ovf_unused)
    );

    // rem[63] set means the 65-bit shifted value already exceeds any divisor.
    assign take    = rem_q[XLEN-1] | cout;
    assign quo_fix = neg_quo_q ? (~quo_q + 1'b1) : quo_q;
    assign rem_fix = neg_rem_q ? (~rem_q + 1'b1) : rem_q;

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        a_d       = a_q;
        b_d       = b_q;
        bmag_d    = bmag_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        cnt_d     = cnt_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        result_d  = result_q;

        case (state_q)
            IDLE: begin
                if (in_valid && !kill_req) begin
                    op_d    = op;
                    a_d     = dividend;
                    b_d     = divisor;
                    state_d = PREP;
                end
            end
            PREP: begin
                neg_quo_d = is_signed && (a_q[XLEN-1] ^ b_q[XLEN-1]) && (b_q != '0);
                neg_rem_d = is_signed && a_q[XLEN-1];
                if (b_q == '0) begin
                    result_d = op_q[1] ? a_q : '1;
                    state_d  = DONE;
                end else if (sgn_ovf) begin
                    result_d = op_q[1] ? '0 : a_q;
                    state_d  = DONE;
                end else begin
                    rem_d   = '0;
                    quo_d   = a_mag;
                    bmag_d  = b_mag;
                    cnt_d   = '0;
                    state_d = ITER;
                end
            end
            ITER: begin
                rem_d = take ? sum : shifted;
                quo_d = {quo_q[XLEN-2:0], take};
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(XLEN - 1)) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                result_d = op_q[1] ? rem_fix : quo_fix;
                state_d  = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Abort wins over everything, including a same-cycle result handoff.
        if (kill_req && (state_q != IDLE)) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            op_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            bmag_q    <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            cnt_q     <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            result_q  <= '0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            a_q       <= a_d;
            b_q       <= b_d;
            bmag_q    <= bmag_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            cnt_q     <= cnt_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            result_q  <= result_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign result    = result_q;
endmodule

// File: tb/tb_div64_seq.sv
// Self-checking bench for div64_seq: vector table plus hand-written
// back-pressure, mid-op reset and (with DIV_KILL_EN) kill sequences.
module tb_div64_seq;
    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  op;
    logic [63:0] dividend;
    logic [63:0] divisor;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] result;
    logic        busy;
`ifdef DIV_KILL_EN
    logic        kill;
`endif

    int checks = 0;
    int errors = 0;

    localparam logic [1:0] DIV  = 2'b00;
    localparam logic [1:0] DIVU = 2'b01;
    localparam logic [1:0] REM  = 2'b10;
    localparam logic [1:0] REMU = 2'b11;
    localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] MINV = 64'h8000_0000_0000_0000;

    typedef struct {
        logic [1:0]  op;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] exp;
        int          lat;
    } vec_t;

    localparam int NV = 17;
    vec_t vecs [NV];

    div64_seq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .dividend  (dividend),
        .divisor   (divisor),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .busy      (busy)
`ifdef DIV_KILL_EN
        ,
        .kill      (kill)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Present an op at a negedge; returns #1 after the accepting edge with
    // the inputs scrambled so late changes would be noticed.
    task automatic start_op(input logic [1:0] o, input logic [63:0] a, input logic [63:0] b);
        @(negedge clk);
        in_valid = 1'b1;
        op       = o;
        dividend = a;
        divisor  = b;
        @(posedge clk);
        #1;
        check("accept_busy", {63'd0, busy}, 64'd1);
        in_valid = 1'b0;
        op       = 2'($urandom);
        dividend = {$urandom, $urandom};
        divisor  = {$urandom, $urandom};
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        while (out_valid !== 1'b1 && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int lat;
        start_op(v.op, v.a, v.b);
        wait_valid(lat);
        check("latency", 64'(lat), 64'(v.lat));
        check("result", result, v.exp);
        $display("vec %0d op=%0d a=%h b=%h result=%h latency=%0d", idx, v.op, v.a, v.b, result, lat);
        @(posedge clk);
        #1;
        check("handoff_idle", {62'd0, out_valid, in_ready}, 64'd1);
    endtask

    initial begin
        int lat;
        int seen;

        vecs[0]  = '{DIVU, 64'd100, 64'd7, 64'd14, 66};
        vecs[1]  = '{REMU, 64'd100, 64'd7, 64'd2, 66};
        vecs[2]  = '{DIV,  64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 66};
        vecs[3]  = '{REM,  64'hFFFF_FFFF_FFFF_FFF9, 64'd2, ONES, 66};
        vecs[4]  = '{REM,  64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 64'd1, 66};
        vecs[5]  = '{DIV,  64'd5, 64'd0, ONES, 1};
        vecs[6]  = '{REMU, 64'd5, 64'd0, 64'd5, 1};
        vecs[7]  = '{DIV,  MINV, ONES, MINV, 1};
        vecs[8]  = '{REM,  MINV, ONES, 64'd0, 1};
        vecs[9]  = '{DIVU, ONES, 64'h8000_0000_0000_0001, 64'd1, 66};
        vecs[10] = '{REMU, ONES, 64'h8000_0000_0000_0001, 64'h7FFF_FFFF_FFFF_FFFE, 66};
        vecs[11] = '{DIV,  64'hFFFF_FFFF_FFFF_FF9C, 64'hFFFF_FFFF_FFFF_FFF9, 64'd14, 66};
        vecs[12] = '{REM,  64'hFFFF_FFFF_FFFF_FF9C, 64'hFFFF_FFFF_FFFF_FFF9, 64'hFFFF_FFFF_FFFF_FFFE, 66};
        vecs[13] = '{DIV,  64'hFFFF_FFFF_FFFF_FFFB, 64'd0, ONES, 1};
        vecs[14] = '{REM,  64'hFFFF_FFFF_FFFF_FFFB, 64'd0, 64'hFFFF_FFFF_FFFF_FFFB, 1};
        vecs[15] = '{DIVU, MINV, ONES, 64'd0, 66};
        vecs[16] = '{DIVU, 64'd9, 64'd3, 64'd3, 66};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        op        = 2'b00;
        dividend  = '0;
        divisor   = '0;
        out_ready = 1'b1;
`ifdef DIV_KILL_EN
        kill      = 1'b0;
`endif
        #3;
        check("reset_ctrl", {61'd0, in_ready, out_valid, busy}, 64'd4);
        check("reset_result", result, 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_reset_ctrl", {61'd0, in_ready, out_valid, busy}, 64'd4);

        for (int i = 0; i < NV; i++) begin
            run_vec(vecs[i], i);
        end

        // Back-pressure: result must hold in DONE while inputs churn.
        out_ready = 1'b0;
        start_op(DIVU, 64'd100, 64'd7);
        wait_valid(lat);
        check("bp_latency", 64'(lat), 64'd66);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            in_valid = ~in_valid;
            op       = 2'($urandom);
            dividend = {$urandom, $urandom};
            divisor  = {$urandom, $urandom};
            @(posedge clk);
            #1;
            check("bp_hold", {out_valid, in_ready, busy, result[60:0]}, {3'b101, 61'd14});
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_release", {61'd0, out_valid, in_ready, busy}, 64'd2);
        $display("backpressure sequence done, result held at 14");

        // Asynchronous reset in the middle of ITER (cnt=30).
        start_op(DIVU, ONES, 64'd3);
        repeat (31) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midreset_ctrl", {61'd0, in_ready, out_valid, busy}, 64'd4);
        check("midreset_result", result, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        $display("mid-op reset sequence done");
        run_vec(vecs[16], 16);

`ifdef DIV_KILL_EN
        // Kill at cnt=10: IDLE at the next edge, no result afterwards.
        start_op(DIVU, 64'd100, 64'd7);
        repeat (11) @(posedge clk);
        #1;
        kill = 1'b1;
        @(posedge clk);
        #1;
        kill = 1'b0;
        check("kill_idle", {61'd0, in_ready, out_valid, busy}, 64'd4);
        seen = 0;
        repeat (80) begin
            @(posedge clk);
            #1;
            if (out_valid) seen++;
        end
        check("kill_no_valid", 64'(seen), 64'd0);
        // kill in IDLE blocks acceptance for that cycle.
        @(negedge clk);
        kill     = 1'b1;
        in_valid = 1'b1;
        op       = DIVU;
        dividend = 64'd9;
        divisor  = 64'd3;
        @(posedge clk);
        #1;
        check("kill_idle_noaccept", {63'd0, busy}, 64'd0);
        kill     = 1'b0;
        in_valid = 1'b0;
        $display("kill sequence done");
        run_vec(vecs[0], 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
